// File: rtl/rvx_response_merger_if.sv
// Stream bundle between the response sources, the merger and the master-side sink.
// The slave modport is the merger's view. The master modport is the environment's view.
interface rvx_response_merger_if #(
  parameter int NUM_SOURCE = 4,
  parameter int BW_DATA    = 32
);
  logic [NUM_SOURCE-1:0]         sinput_valid_list;
  logic [NUM_SOURCE-1:0]         sinput_ready_list;
  logic [NUM_SOURCE*BW_DATA-1:0] sinput_data_list;
  logic [NUM_SOURCE-1:0]         sinput_last_list;
  logic                          moutput_valid;
  logic                          moutput_ready;
  logic [BW_DATA-1:0]            moutput_data;
  logic                          moutput_last;
  logic [NUM_SOURCE-1:0]         moutput_source;

  modport slave (
    input  sinput_valid_list,
    input  sinput_data_list,
    input  sinput_last_list,
    input  moutput_ready,
    output sinput_ready_list,
    output moutput_valid,
    output moutput_data,
    output moutput_last,
    output moutput_source
  );

  modport master (
    output sinput_valid_list,
    output sinput_data_list,
    output sinput_last_list,
    output moutput_ready,
    input  sinput_ready_list,
    input  moutput_valid,
    input  moutput_data,
    input  moutput_last,
    input  moutput_source
  );
endinterface

// File: rtl/rvx_response_merger.sv
// Many-to-one response merger: round-robin arbitration, burst lock until `last`,
// one registered output stage, and a one-hot tag giving the source of each output beat.
module rvx_response_merger #(
  parameter int NUM_SOURCE = 4,
  parameter int BW_DATA    = 32
) (
  input  logic                 clk,
  input  logic                 rstnn,
  rvx_response_merger_if.slave bus,
  output logic                 idle
);
  localparam int IDX_W = (NUM_SOURCE > 1) ? $clog2(NUM_SOURCE) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  lock_state_e           lock_q, lock_d;
  idx_t                  lock_owner_q, lock_owner_d;
  idx_t                  rr_pointer_q, rr_pointer_d;
  logic                  out_valid_q, out_valid_d;
  logic [BW_DATA-1:0]    out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [NUM_SOURCE-1:0] out_source_q, out_source_d;

  logic [NUM_SOURCE-1:0] grant;
  idx_t                  grant_idx;
  logic [BW_DATA-1:0]    grant_data;
  logic                  grant_last;
  logic                  load_en;
  logic                  transfer;

  // The explicit wrap keeps the pointer in range when NUM_SOURCE is not a power of two.
  function automatic idx_t next_index(input idx_t k);
    if (32'(k) == 32'(NUM_SOURCE - 1)) return '0;
    return k + idx_t'(1);
  endfunction

  always_comb begin
    int unsigned pos;
    idx_t        sel;
    grant = '0;
    pos   = 0;
    sel   = '0;
    if (lock_q == LOCKED) begin
      for (int unsigned i = 0; i < NUM_SOURCE; i++) begin
        if (idx_t'(i) == lock_owner_q) grant[i] = bus.sinput_valid_list[i];
      end
    end else begin
      for (int unsigned off = 0; off < NUM_SOURCE; off++) begin
        pos = 32'(rr_pointer_q) + off;
        if (pos >= 32'(NUM_SOURCE)) pos = pos - 32'(NUM_SOURCE);
        sel = idx_t'(pos);
        if ((grant == '0) && bus.sinput_valid_list[sel]) grant[sel] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    grant_last = 1'b0;
    for (int unsigned i = 0; i < NUM_SOURCE; i++) begin
      if (grant[i]) begin
        grant_idx  = idx_t'(i);
        grant_data = bus.sinput_data_list[i*BW_DATA +: BW_DATA];
        grant_last = bus.sinput_last_list[i];
      end
    end
  end

  assign load_en  = !out_valid_q || bus.moutput_ready;
  assign transfer = load_en && (grant != '0);
  // Gating with rstnn keeps ready low for the whole reset, even while sources hold valid.
  assign bus.sinput_ready_list = (load_en && rstnn) ? grant : '0;

  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    rr_pointer_d = rr_pointer_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_source_d = out_source_q;

    if (transfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = grant_data;
      out_last_d   = grant_last;
      out_source_d = grant;
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end

    case (lock_q)
      UNLOCKED: begin
        if (transfer) begin
          if (grant_last) begin
            rr_pointer_d = next_index(grant_idx);
          end else begin
            lock_d       = LOCKED;
            lock_owner_d = grant_idx;
          end
        end
      end
      LOCKED: begin
        if (transfer && grant_last) begin
          lock_d       = UNLOCKED;
          rr_pointer_d = next_index(lock_owner_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      lock_q       <= UNLOCKED;
      lock_owner_q <= '0;
      rr_pointer_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_source_q <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      rr_pointer_q <= rr_pointer_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_source_q <= out_source_d;
    end
  end

  assign bus.moutput_valid  = out_valid_q;
  assign bus.moutput_data   = out_data_q;
  assign bus.moutput_last   = out_last_q;
  assign bus.moutput_source = out_source_q;
  assign idle               = !out_valid_q && (lock_q == UNLOCKED);

  // Sources must hold valid until it is accepted.
  for (genvar g = 0; g < NUM_SOURCE; g++) begin : g_src_hold
    a_valid_held: assert property (
      @(posedge clk) disable iff (!rstnn)
      (bus.sinput_valid_list[g] && !bus.sinput_ready_list[g]) |=> bus.sinput_valid_list[g]
    ) else $error("source %0d dropped valid before ready", g);
  end
endmodule

// File: tb/tb_rvx_response_merger.sv
// Directed bench for rvx_response_merger: per-source beat queues drive the inputs,
// and the expected output beats are queued up front and checked as they leave.
module tb_rvx_response_merger;
  localparam int NS = 4;
  localparam int BW = 32;

  logic clk = 1'b0;
  logic rstnn;
  logic idle;

  always #5 clk = ~clk;

  rvx_response_merger_if #(.NUM_SOURCE(NS), .BW_DATA(BW)) bus ();

  rvx_response_merger #(.NUM_SOURCE(NS), .BW_DATA(BW)) dut (
    .clk   (clk),
    .rstnn (rstnn),
    .bus   (bus),
    .idle  (idle)
  );

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic [NS-1:0] src;
  } exp_t;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic [7:0]    gap;
  } beat_t;

  exp_t  exp_q[$];
  beat_t src_q[NS][$];
  int    gap_cnt[NS];
  logic  out_ready;
  int    compared   = 0;
  int    mismatched = 0;

  logic          obs_valid;
  logic [NS-1:0] obs_ready;
  logic          obs_idle;
  logic [BW-1:0] obs_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    end
  endtask

  task automatic push_src(input int s, input logic [BW-1:0] d, input logic l, input int gap);
    beat_t b;
    b.data = d;
    b.last = l;
    b.gap  = 8'(gap);
    src_q[s].push_back(b);
  endtask

  task automatic push_exp(input logic [BW-1:0] d, input logic l, input logic [NS-1:0] s);
    exp_t e;
    e.data = d;
    e.last = l;
    e.src  = s;
    exp_q.push_back(e);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0 && gap_cnt[i] == 0) begin
        bus.sinput_valid_list[i]         = 1'b1;
        bus.sinput_data_list[i*BW +: BW] = src_q[i][0].data;
        bus.sinput_last_list[i]          = src_q[i][0].last;
      end else begin
        bus.sinput_valid_list[i]         = 1'b0;
        bus.sinput_data_list[i*BW +: BW] = '0;
        bus.sinput_last_list[i]          = 1'b0;
      end
    end
    bus.moutput_ready = out_ready;
  endtask

  // One clock: drive, sample at the falling edge, retire accepted source beats after the rising edge.
  task automatic tick();
    logic [NS-1:0] acc;
    exp_t          e;
    drive_inputs();
    @(negedge clk);
    obs_valid = bus.moutput_valid;
    obs_ready = bus.sinput_ready_list;
    obs_idle  = idle;
    obs_data  = bus.moutput_data;
    acc       = bus.sinput_valid_list & bus.sinput_ready_list;
    if (bus.moutput_valid && bus.moutput_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat_src", 64'(bus.moutput_source), 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("out_data",   64'(bus.moutput_data),   64'(e.data));
        check("out_last",   64'(bus.moutput_last),   64'(e.last));
        check("out_source", 64'(bus.moutput_source), 64'(e.src));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) begin
        src_q[i].delete(0);
        gap_cnt[i] = (src_q[i].size() > 0) ? int'(src_q[i][0].gap) : 0;
      end else if (gap_cnt[i] > 0) begin
        gap_cnt[i]--;
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},  64'(bus.moutput_valid),     64'd0);
    check({tag, "_data"},   64'(bus.moutput_data),      64'd0);
    check({tag, "_last"},   64'(bus.moutput_last),      64'd0);
    check({tag, "_source"}, 64'(bus.moutput_source),    64'd0);
    check({tag, "_idle"},   64'(idle),                  64'd1);
    check({tag, "_ready"},  64'(bus.sinput_ready_list), 64'd0);
  endtask

  task automatic apply_reset();
    rstnn = 1'b0;
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      gap_cnt[i] = 0;
    end
    exp_q.delete();
    drive_inputs();
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk);
    #1;
    rstnn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bubbles;
    int n;
    bit seen;

    out_ready = 1'b1;
    rstnn     = 1'b0;
    for (int i = 0; i < NS; i++) gap_cnt[i] = 0;

    // Reset, then nothing valid.
    apply_reset();
    tick();
    check("idle_after_reset",  64'(obs_idle),  64'd1);
    check("valid_after_reset", 64'(obs_valid), 64'd0);
    check("ready_after_reset", 64'(obs_ready), 64'd0);

    // Single beat from source 2.
    push_src(2, 32'hA5A5_0002, 1'b1, 0);
    push_exp(32'hA5A5_0002, 1'b1, 4'b0100);
    tick();
    check("single_ready", 64'(obs_ready), 64'b0100);
    drain("single", 5);

    // Pointer now sits on 3, so source 3 wins over source 0.
    push_src(0, 32'h0000_0C00, 1'b1, 0);
    push_src(3, 32'h0000_0C03, 1'b1, 0);
    push_exp(32'h0000_0C03, 1'b1, 4'b1000);
    push_exp(32'h0000_0C00, 1'b1, 4'b0001);
    drain("ptr3", 10);

    // Fairness: all four sources keep single-beat bursts valid.
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NS; s++) begin
        push_src(s, 32'hF000_0000 | 32'(r << 8) | 32'(s), 1'b1, 0);
        push_exp(32'hF000_0000 | 32'(r << 8) | 32'(s), 1'b1, 4'(1 << s));
      end
    end
    tick();
    check("fair_first_empty", 64'(obs_valid), 64'd0);
    for (int k = 0; k < 3 * NS; k++) begin
      tick();
      check("fair_no_bubble", 64'(obs_valid), 64'd1);
    end
    check("fair_drained", 64'(exp_q.size()), 64'd0);

    // Burst lock: move the pointer to 1, then a 3-beat burst from source 1 with a 2-cycle gap.
    apply_reset();
    push_src(0, 32'hB000_0000, 1'b1, 0);
    push_exp(32'hB000_0000, 1'b1, 4'b0001);
    drain("prime", 5);
    push_src(1, 32'hB100_0000, 1'b0, 0);
    push_src(1, 32'hB100_0001, 1'b0, 0);
    push_src(1, 32'hB100_0002, 1'b1, 2);
    push_src(0, 32'hB000_0010, 1'b1, 0);
    push_src(3, 32'hB300_0000, 1'b1, 0);
    push_exp(32'hB100_0000, 1'b0, 4'b0010);
    push_exp(32'hB100_0001, 1'b0, 4'b0010);
    push_exp(32'hB100_0002, 1'b1, 4'b0010);
    push_exp(32'hB300_0000, 1'b1, 4'b1000);
    push_exp(32'hB000_0010, 1'b1, 4'b0001);
    bubbles = 0;
    seen    = 1'b0;
    n       = 0;
    while (exp_q.size() > 0 && n < 30) begin
      tick();
      n++;
      if (obs_valid) begin
        seen = 1'b1;
      end else if (seen) begin
        bubbles++;
        check("lock_bubble_ready", 64'(obs_ready & 4'b1101), 64'd0);
        check("lock_bubble_idle",  64'(obs_idle),            64'd0);
      end
    end
    check("lock_drained", 64'(exp_q.size()), 64'd0);
    check("lock_bubbles", 64'(bubbles),      64'd2);

    // Backpressure: hold a beat for 5 cycles, then hand over and reload in one cycle.
    push_src(1, 32'hC100_0000, 1'b1, 0);
    push_src(2, 32'hC200_0000, 1'b1, 0);
    push_exp(32'hC100_0000, 1'b1, 4'b0010);
    push_exp(32'hC200_0000, 1'b1, 4'b0100);
    out_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", 64'(obs_valid), 64'd1);
      check("bp_ready", 64'(obs_ready), 64'd0);
      check("bp_data",  64'(obs_data),  64'hC100_0000);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", 64'(obs_ready), 64'b0100);
    tick();
    check("bp_valid_stays", 64'(obs_valid), 64'd1);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a burst from source 0 (pointer is 3, so 0 wins over 2).
    push_src(0, 32'hD000_0000, 1'b0, 0);
    push_src(0, 32'hD000_0001, 1'b1, 0);
    push_src(2, 32'hD200_0000, 1'b1, 0);
    tick();
    check("mid_grant_src0", 64'(obs_ready), 64'b0001);
    rstnn = 1'b0;
    src_q[0].delete();
    gap_cnt[0] = 0;
    exp_q.delete();
    drive_inputs();
    @(negedge clk);
    check_reset_values("mid_rst");
    @(posedge clk);
    #1;
    rstnn = 1'b1;
    push_exp(32'hD200_0000, 1'b1, 4'b0100);
    tick();
    check("post_reset_grant", 64'(obs_ready), 64'b0100);
    drain("post_reset", 5);
    tick();
    check("final_idle", 64'(obs_idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/rvx_response_merger.md
Name: rvx_response_merger

Overview:
- Many-to-one merger for valid/ready/data streams.
- Sits opposite the one-to-many request splitter. The splitter fans one request out to selected targets; this block collects the target responses back into one master-side stream.
- Round-robin arbitration, burst locking on `last`, one registered output stage.
- Reports the one-hot source of each output beat, so the initiator can match responses to requests.

Parameters:
- NUM_SOURCE, 4, number of response sources (≥1)
- BW_DATA, 32, payload width per beat

Ports:
- clk  input  1  clock
- rstnn  input  1  asynchronous active-low reset
- sinput_valid_list  input  NUM_SOURCE  per-source beat valid
- sinput_ready_list  output  NUM_SOURCE  per-source beat accepted
- sinput_data_list  input  NUM_SOURCE*BW_DATA  payloads; source i at [(i+1)*BW_DATA-1 -: BW_DATA]
- sinput_last_list  input  NUM_SOURCE  per-source end-of-burst flag
- moutput_valid  output  1  merged beat valid
- moutput_ready  input  1  merged beat accepted
- moutput_data  output  BW_DATA  merged payload
- moutput_last  output  1  end-of-burst of merged beat
- moutput_source  output  NUM_SOURCE  one-hot source of current output beat
- idle  output  1  no buffered beat and no burst lock

Behaviour:
- Clock and reset: single clock `clk`. Reset `rstnn` is asynchronous and active-low.
- Reset values:
  - moutput_valid=0, moutput_data=0, moutput_last=0, moutput_source=0
  - lock=0, lock_owner=0, rr_pointer=0
  - idle=1, sinput_ready_list=0
- Output register load:
  - load_en = !moutput_valid || moutput_ready.
  - The register holds its value while moutput_valid=1 and moutput_ready=0.
- Grant (combinational, one-hot or zero):
  - If lock=1: grant = one-hot(lock_owner) & sinput_valid_list.
  - Otherwise: the first valid source scanning rr_pointer, rr_pointer+1, … wrapping modulo NUM_SOURCE.
- Input handshake:
  - sinput_ready_list[i] = load_en & grant[i].
  - A transfer on source i occurs when valid[i] & ready[i].
  - At most one transfer per cycle.
  - sinput_ready_list must not depend on sinput_ready of the same source being asserted; ready may depend on valid.
- On a transfer from source k:
  - moutput_valid ← 1 next cycle; data/last captured from k; moutput_source ← one-hot(k).
- On load_en with no transfer: moutput_valid ← 0.
- Performance: latency is 1 cycle from input transfer to moutput_valid. Throughput is 1 beat/cycle when moutput_ready stays high.
- Lock state machine, two states:
  - UNLOCKED + transfer from k with last=0 → LOCKED, lock_owner=k.
  - UNLOCKED + transfer from k with last=1 → stays UNLOCKED, rr_pointer=(k+1) mod NUM_SOURCE.
  - LOCKED + transfer from the owner with last=1 → UNLOCKED, rr_pointer=(lock_owner+1) mod NUM_SOURCE.
  - LOCKED with the owner not valid → no source granted (bubble). Other sources are never interleaved mid-burst.
- Pointer wrap: if NUM_SOURCE is not a power of two, the pointer wraps explicitly from NUM_SOURCE-1 to 0. With NUM_SOURCE=1 the pointer stays 0.
- Simultaneous events: output consumed and a new input captured in the same cycle. Valid stays 1 and the register updates.
- idle = !moutput_valid & !lock.
- Reset mid-burst: lock is cleared, the buffered beat is dropped, and the pointer returns to 0. Sources must restart bursts.
- Protocol obligations on sources: valid, data and last are held stable until ready.
- Violation check: a simulation-only assertion flags a source dropping valid without ready.

Test Plan:
- Reset, then all sources idle → idle=1, moutput_valid=0, sinput_ready_list=4'b0000.
- Single beat: src2 valid, data=0xA5A5_0002, last=1, moutput_ready=1 → next cycle moutput_valid=1, data=0xA5A5_0002, source=4'b0100, last=1; then rr_pointer=3.
- Fairness: all 4 sources continuously valid with last=1, moutput_ready=1 → output source order 0,1,2,3,0,1,…; one beat per cycle, no bubbles.
- Burst lock:
  - Stimulus: src1 sends 3 beats (last=0,0,1) while src0 and src3 stay valid; src1 drops valid for 2 cycles between beats 1 and 2.
  - Required response: output shows only src1 beats, with 2 bubble cycles, then src3 (pointer=2, src2 not valid).
- Backpressure: moutput_ready=0 for 5 cycles with an output beat held → moutput_data stable, sinput_ready_list=0. On ready=1, the held beat and a new beat transfer in the same cycle, and moutput_valid stays 1.
- Reset mid-burst: assert rstnn=0 after src0's first beat (last=0) → all outputs return to reset values within the reset assertion; after release src2 is granted immediately.
